imm_decode_stage: RTL and testbench
===================================

# imm_decode_stage

Pipelined, parametrised immediate generator between instruction fetch and the register-read stage. Accepts one 32-bit instruction per cycle over a valid/ready handshake, decodes its format from the opcode, and produces a sign-extended XLEN-bit immediate plus format and illegal-opcode flags. Output is registered behind a 2-entry skid buffer, so fetch and execute backpressure are decoupled without a combinational ready path. A saturating counter reports illegal opcodes seen.

## Interface
- XLEN, 64, immediate/output width; legal values 32 or 64
- CNT_W, 16, illegal-opcode counter width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous pipeline flush
- in_valid  in  1  instruction present
- in_ready  out  1  stage can accept; registered, equals "skid entry empty"
- in_instr  in  32  instruction word
- out_valid  out  1  decoded entry present
- out_ready  in  1  downstream accepts
- out_instr  out  32  instruction passed through
- out_imm  out  XLEN  sign-extended immediate
- out_fmt  out  3  format code
- out_illegal  out  1  opcode not recognised
- illegal_cnt  out  CNT_W  saturating count of accepted illegal instructions

## Operation
- Opcode = instr[6:0]. Decode:
  - LOAD 0000011, OP-IMM 0010011, JALR 1100111 -> FMT_I: imm = sext(instr[31:20])
  - STORE 0100011 -> FMT_S: sext({instr[31:25], instr[11:7]})
  - BRANCH 1100011 -> FMT_B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0})
  - LUI 0110111, AUIPC 0010111 -> FMT_U: sext({instr[31:12], 12'b0})
  - JAL 1101111 -> FMT_J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0})
  - anything else -> FMT_NONE, out_illegal=1, out_imm=0 (never X)
- Format codes: I=0, S=1, B=2, U=3, J=4, NONE=7.
- Sign extension always from the immediate's top bit (instr[31]) to XLEN; for XLEN=32, U-type has no extension.
- Buffer occupancy state: EMPTY, ONE (output reg valid), TWO (output + skid valid).
  - EMPTY: accept -> ONE.
  - ONE: accept & out_ready -> ONE (output reloaded); accept & !out_ready -> TWO (new entry to skid); !accept & out_ready -> EMPTY.
  - TWO: in_ready=0; out_ready -> ONE, skid moves to output.
- Ordering strictly FIFO; no entry dropped or duplicated.
- illegal_cnt increments by 1 on each accepted (in_valid & in_ready) illegal instruction; holds at all-ones; cleared only by rst, not by flush.

## Timing
- Latency 1 cycle: instruction accepted at edge N is on out_* after edge N when buffer was EMPTY or drained that cycle.
- Throughput 1/cycle with out_ready held high.
- out_* stable while out_valid & !out_ready.
- in_ready is a flop output; no combinational path from out_ready to in_ready.
- flush: next edge -> EMPTY, out_valid=0, in_ready=1; an input accepted in the flush cycle is discarded and not counted.
- rst (async, any time including mid-transfer): out_valid=0, in_ready=1 after release, out_imm=0, out_instr=0, out_fmt=NONE, out_illegal=0, illegal_cnt=0, state EMPTY.

## Configuration
- IMM_DECODE_UJ_EN: defined -> LUI, AUIPC, JAL decode to FMT_U/FMT_J as above. Undefined -> those opcodes decode as FMT_NONE, out_illegal=1, imm=0, and count toward illegal_cnt.

## Structure
- Shared package: opcode constants, format-code enum (FMT_I..FMT_NONE), decoded-entry struct {instr, imm, fmt, illegal}.
- One combinational sub-module imm_decode_core (instr -> entry, XLEN parameter); the stage holds the skid buffer, state and counter.

## Test plan
- lw 0xFF813083, XLEN=64 -> out_imm=0xFFFFFFFFFFFFFFF8, out_fmt=0, out_illegal=0, 1-cycle latency.
- sw 0x00512623 -> imm=0x000000000000000C, fmt=1; beq 0xFE000EE3 -> imm=0xFFFFFFFFFFFFFFFC, fmt=2.
- lui 0x123450B7 -> imm=0x0000000012345000, fmt=3 with macro; without macro -> fmt=7, illegal=1, illegal_cnt=1.
- Stream 8 instrs, out_ready low 3 cycles mid-stream -> in_ready drops after 2 held entries, all 8 emerge in order, none lost.
- Illegal 0x0000007F repeated, CNT_W=2 -> illegal_cnt 1,2,3,3; flush then rst -> flush keeps 3, rst clears to 0.
- Assert rst while in TWO -> out_valid=0 immediately, outputs at reset values, next accept behaves from EMPTY.

Source files
------------

// File: rtl/imm_decode_stage_pkg.sv
// Shared definitions for the immediate decode stage: opcodes, format codes
// and the decoded-entry record that travels through the skid buffer.
package imm_decode_stage_pkg;

  localparam int IMM_MAX = 64;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    FMT_I    = 3'd0,
    FMT_S    = 3'd1,
    FMT_B    = 3'd2,
    FMT_U    = 3'd3,
    FMT_J    = 3'd4,
    FMT_NONE = 3'd7
  } fmt_e;

  // The immediate is always carried at full 64-bit width; the stage slices
  // it down to XLEN at its outputs.
  typedef struct packed {
    logic [31:0]        instr;
    logic [IMM_MAX-1:0] imm;
    fmt_e               fmt;
    logic               illegal;
  } entry_t;

  function automatic entry_t reset_entry();
    entry_t e;
    e.instr   = '0;
    e.imm     = '0;
    e.fmt     = FMT_NONE;
    e.illegal = 1'b0;
    return e;
  endfunction

endpackage

// File: rtl/imm_decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the immediate decode stage.
// The master modport is the surrounding pipeline, the slave modport the stage.
interface imm_decode_stage_if #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [XLEN-1:0]   out_imm;
  logic [2:0]        out_fmt;
  logic              out_illegal;
  logic [CNT_W-1:0]  illegal_cnt;

  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_instr, out_imm, out_fmt, out_illegal, illegal_cnt
  );

  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_instr, out_imm, out_fmt, out_illegal, illegal_cnt
  );
endinterface

// File: rtl/imm_decode_stage_core.sv
// Combinational immediate decoder: instruction word -> decoded entry.
// Macro IMM_DECODE_UJ_EN enables LUI/AUIPC/JAL decoding; without it those
// opcodes are reported as illegal.
module imm_decode_core
  import imm_decode_stage_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0] i_instr,
  output entry_t      o_entry
);

  logic w_s;
  assign w_s = i_instr[31];

  // Select the immediate layout from the opcode; unknown opcodes give a zero immediate.
  always_comb begin
    o_entry.instr   = i_instr;
    o_entry.imm     = '0;
    o_entry.fmt     = FMT_NONE;
    o_entry.illegal = 1'b1;
    case (i_instr[6:0])
      OPC_LOAD, OPC_OP_IMM, OPC_JALR: begin
        o_entry.imm     = {{52{w_s}}, i_instr[31:20]};
        o_entry.fmt     = FMT_I;
        o_entry.illegal = 1'b0;
      end
      OPC_STORE: begin
        o_entry.imm     = {{52{w_s}}, i_instr[31:25], i_instr[11:7]};
        o_entry.fmt     = FMT_S;
        o_entry.illegal = 1'b0;
      end
      OPC_BRANCH: begin
        o_entry.imm     = {{51{w_s}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
        o_entry.fmt     = FMT_B;
        o_entry.illegal = 1'b0;
      end
`ifdef IMM_DECODE_UJ_EN
      OPC_LUI, OPC_AUIPC: begin
        o_entry.imm     = {{32{w_s}}, i_instr[31:12], 12'b0};
        o_entry.fmt     = FMT_U;
        o_entry.illegal = 1'b0;
      end
      OPC_JAL: begin
        o_entry.imm     = {{43{w_s}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
        o_entry.fmt     = FMT_J;
        o_entry.illegal = 1'b0;
      end
`endif
      default: ;
    endcase
    if (XLEN == 32) begin
      o_entry.imm[IMM_MAX-1:32] = '0;
    end
  end

endmodule

// File: rtl/imm_decode_stage.sv
// Immediate decode pipeline stage: decodes one instruction per cycle into a
// registered output backed by a one-entry skid register, so in_ready is a
// flop and never depends combinationally on out_ready. Also keeps a
// saturating count of accepted illegal instructions.
// Macro IMM_DECODE_UJ_EN (see imm_decode_core) enables U/J formats.
module imm_decode_stage
  import imm_decode_stage_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  imm_decode_stage_if.slave     bus
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_next;
  entry_t           r_out;
  entry_t           r_skid;
  entry_t           w_dec;
  logic             r_in_ready;
  logic [CNT_W-1:0] r_cnt;
  logic             w_accept;
  logic             w_load_out_dec;
  logic             w_load_out_skid;
  logic             w_load_skid;

  imm_decode_core #(.XLEN(XLEN)) u_core (
    .i_instr (bus.in_instr),
    .o_entry (w_dec)
  );

  assign w_accept = bus.in_valid & r_in_ready;

  // Occupancy transitions and which register each new entry lands in.
  always_comb begin
    w_next          = r_state;
    w_load_out_dec  = 1'b0;
    w_load_out_skid = 1'b0;
    w_load_skid     = 1'b0;
    if (flush) begin
      w_next = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            w_next         = S_ONE;
            w_load_out_dec = 1'b1;
          end
        end
        S_ONE: begin
          if (w_accept && bus.out_ready) begin
            w_load_out_dec = 1'b1;
          end else if (w_accept) begin
            w_next      = S_TWO;
            w_load_skid = 1'b1;
          end else if (bus.out_ready) begin
            w_next = S_EMPTY;
          end
        end
        S_TWO: begin
          if (bus.out_ready) begin
            w_next          = S_ONE;
            w_load_out_skid = 1'b1;
          end
        end
        default: w_next = S_EMPTY;
      endcase
    end
  end

  // Occupancy state and the registered ready, which is high whenever the skid slot is free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_next;
      r_in_ready <= (w_next != S_TWO);
    end
  end

  // Output and skid registers; the output reloads from the skid first to keep FIFO order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out  <= reset_entry();
      r_skid <= reset_entry();
    end else begin
      if (w_load_out_dec) begin
        r_out <= w_dec;
      end else if (w_load_out_skid) begin
        r_out <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= w_dec;
      end
    end
  end

  // Saturating illegal counter; an instruction accepted during a flush is discarded and not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_accept && !flush && w_dec.illegal && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.in_ready    = r_in_ready;
  assign bus.out_valid   = (r_state != S_EMPTY);
  assign bus.out_instr   = r_out.instr;
  assign bus.out_imm     = r_out.imm[XLEN-1:0];
  assign bus.out_fmt     = r_out.fmt;
  assign bus.out_illegal = r_out.illegal;
  assign bus.illegal_cnt = r_cnt;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed testbench for imm_decode_stage (XLEN=64, CNT_W=2).
// Expectations for LUI/JAL follow the IMM_DECODE_UJ_EN build setting.
module tb_imm_decode_stage;

  logic clk;
  logic rst;
  logic flush;
  int   checks;
  int   errors;
  int   expCnt;

  imm_decode_stage_if #(.XLEN(64), .CNT_W(2)) bus ();

  imm_decode_stage #(.XLEN(64), .CNT_W(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.out_imm !== 64'h0) begin errors++; $display("[TB] FAIL reset_out_imm: got %h expected 0", bus.out_imm); end
    checks++; if (bus.out_instr !== 32'h0) begin errors++; $display("[TB] FAIL reset_out_instr: got %h expected 0", bus.out_instr); end
    checks++; if (bus.out_fmt !== 3'd7) begin errors++; $display("[TB] FAIL reset_out_fmt: got %0d expected 7", bus.out_fmt); end
    checks++; if (bus.out_illegal !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_illegal: got %b expected 0", bus.out_illegal); end
    checks++; if (bus.illegal_cnt !== 2'd0) begin errors++; $display("[TB] FAIL reset_illegal_cnt: got %0d expected 0", bus.illegal_cnt); end
  endtask

  task automatic test_single(input string nm, input logic [31:0] ins, input logic [63:0] eImm,
                             input logic [2:0] eFmt, input logic eIll);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_instr  = ins;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (eIll && expCnt < 3) expCnt++;
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL %s_valid: got %b expected 1", nm, bus.out_valid); end
    checks++; if (bus.out_instr !== ins) begin errors++; $display("[TB] FAIL %s_instr: got %h expected %h", nm, bus.out_instr, ins); end
    checks++; if (bus.out_imm !== eImm) begin errors++; $display("[TB] FAIL %s_imm: got %h expected %h", nm, bus.out_imm, eImm); end
    checks++; if (bus.out_fmt !== eFmt) begin errors++; $display("[TB] FAIL %s_fmt: got %0d expected %0d", nm, bus.out_fmt, eFmt); end
    checks++; if (bus.out_illegal !== eIll) begin errors++; $display("[TB] FAIL %s_illegal: got %b expected %b", nm, bus.out_illegal, eIll); end
    checks++; if (bus.illegal_cnt !== 2'(expCnt)) begin errors++; $display("[TB] FAIL %s_cnt: got %0d expected %0d", nm, bus.illegal_cnt, expCnt); end
    @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL %s_drain: got %b expected 0", nm, bus.out_valid); end
  endtask

  task automatic test_stream();
    logic [31:0] vec [8];
    int   sent;
    int   recv;
    int   occ;
    logic acc;
    logic deq;
    logic prevStall;
    logic sawBackpressure;
    logic [31:0] held;
    sent = 0; recv = 0; occ = 0; prevStall = 1'b0; sawBackpressure = 1'b0; held = '0;
    for (int i = 0; i < 8; i++) vec[i] = 32'h00000013 | (32'(i + 1) << 20);
    for (int cyc = 0; cyc < 40 && recv < 8; cyc++) begin
      bus.out_ready = !(cyc >= 3 && cyc < 6);
      bus.in_valid  = (sent < 8);
      bus.in_instr  = (sent < 8) ? vec[sent] : 32'h0;
      checks++; if (bus.in_ready !== (occ < 2)) begin errors++; $display("[TB] FAIL stream_in_ready c%0d: got %b expected %b", cyc, bus.in_ready, occ < 2); end
      checks++; if (bus.out_valid !== (occ > 0)) begin errors++; $display("[TB] FAIL stream_out_valid c%0d: got %b expected %b", cyc, bus.out_valid, occ > 0); end
      if (bus.in_ready === 1'b0) sawBackpressure = 1'b1;
      acc = bus.in_valid && (bus.in_ready === 1'b1);
      deq = (bus.out_valid === 1'b1) && bus.out_ready;
      if ((bus.out_valid === 1'b1) && !bus.out_ready) begin
        if (prevStall) begin
          checks++; if (bus.out_instr !== held) begin errors++; $display("[TB] FAIL stream_stable c%0d: got %h expected %h", cyc, bus.out_instr, held); end
        end
        held = bus.out_instr;
        prevStall = 1'b1;
      end else begin
        prevStall = 1'b0;
      end
      if (deq) begin
        checks++; if (bus.out_instr !== vec[recv]) begin errors++; $display("[TB] FAIL stream_order %0d: got %h expected %h", recv, bus.out_instr, vec[recv]); end
        checks++; if (bus.out_imm !== 64'(recv + 1)) begin errors++; $display("[TB] FAIL stream_imm %0d: got %h expected %h", recv, bus.out_imm, 64'(recv + 1)); end
        recv++;
      end
      @(posedge clk); #1;
      if (acc) sent++;
      occ = occ + (acc ? 1 : 0) - (deq ? 1 : 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    checks++; if (recv != 8) begin errors++; $display("[TB] FAIL stream_count: got %0d expected 8", recv); end
    checks++; if (!sawBackpressure) begin errors++; $display("[TB] FAIL stream_backpressure: got 0 expected 1"); end
    @(posedge clk); #1;
  endtask

  task automatic test_illegal_sat();
    rst = 1'b1; #1; rst = 1'b0;
    expCnt = 0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 32'h0000007F;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (expCnt < 3) expCnt++;
      checks++; if (bus.illegal_cnt !== 2'(expCnt)) begin errors++; $display("[TB] FAIL sat_cnt %0d: got %0d expected %0d", i, bus.illegal_cnt, expCnt); end
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    checks++; if (bus.illegal_cnt !== 2'd3) begin errors++; $display("[TB] FAIL flush_cnt: got %0d expected 3", bus.illegal_cnt); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_in_ready: got %b expected 1", bus.in_ready); end
    rst = 1'b1; #1;
    expCnt = 0;
    checks++; if (bus.illegal_cnt !== 2'd0) begin errors++; $display("[TB] FAIL rst_cnt: got %0d expected 0", bus.illegal_cnt); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_in_two();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 32'hFF813083;
    @(posedge clk); #1;
    bus.in_instr  = 32'h00512623;
    @(posedge clk); #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL two_in_ready: got %b expected 0", bus.in_ready); end
    checks++; if (bus.out_instr !== 32'hFF813083) begin errors++; $display("[TB] FAIL two_head: got %h expected ff813083", bus.out_instr); end
    bus.in_instr = 32'hFE000EE3;
    #2; rst = 1'b1; #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL two_rst_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.out_imm !== 64'h0) begin errors++; $display("[TB] FAIL two_rst_imm: got %h expected 0", bus.out_imm); end
    checks++; if (bus.out_fmt !== 3'd7) begin errors++; $display("[TB] FAIL two_rst_fmt: got %0d expected 7", bus.out_fmt); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL two_rst_in_ready: got %b expected 1", bus.in_ready); end
    rst = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++; if (bus.out_instr !== 32'hFE000EE3) begin errors++; $display("[TB] FAIL after_rst_instr: got %h expected fe000ee3", bus.out_instr); end
    checks++; if (bus.out_imm !== 64'hFFFFFFFFFFFFFFFC) begin errors++; $display("[TB] FAIL after_rst_imm: got %h expected fffffffffffffffc", bus.out_imm); end
    @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL after_rst_drain: got %b expected 0", bus.out_valid); end
  endtask

  // Reset, then run each scenario in turn and print the summary.
  initial begin
    checks = 0; errors = 0; expCnt = 0;
    rst = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_instr = 32'h0; bus.out_ready = 1'b1;
    #1;
    test_reset();
    #11 rst = 1'b0;
    @(posedge clk); #1;
    test_single("lw",  32'hFF813083, 64'hFFFFFFFFFFFFFFF8, 3'd0, 1'b0);
    test_single("sw",  32'h00512623, 64'h000000000000000C, 3'd1, 1'b0);
    test_single("beq", 32'hFE000EE3, 64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0);
`ifdef IMM_DECODE_UJ_EN
    test_single("lui", 32'h123450B7, 64'h0000000012345000, 3'd3, 1'b0);
    test_single("jal", 32'hFFDFF06F, 64'hFFFFFFFFFFFFFFFC, 3'd4, 1'b0);
`else
    test_single("lui", 32'h123450B7, 64'h0, 3'd7, 1'b1);
    test_single("jal", 32'hFFDFF06F, 64'h0, 3'd7, 1'b1);
`endif
    test_stream();
    test_illegal_sat();
    test_reset_in_two();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
